// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver, 8N1, LSB first. This is the receive half of the FPGA<->PC
//   serial link. The asynchronous rx line passes through a two-flop
//   synchroniser. The receiver detects the start bit, samples each bit at its
//   mid-point and delivers the byte with a one-cycle valid strobe. If the stop
//   bit is sampled low, the byte is discarded and a one-cycle frame_err pulse
//   is raised.
//
// Parameters
//   bd_divider : clock cycles per bit (clock_frequency / baudrate), 4..65535
//
// Ports
//   clk       : system clock, all logic on posedge
//   rst       : synchronous, active-high reset
//   rx        : serial line from PC, asynchronous, idles high
//   data_out  : last correctly received byte, held until the next good frame
//   out_valid : one-cycle pulse, data_out updated this cycle
//   frame_err : one-cycle pulse, stop bit sampled low, byte discarded
//   busy      : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned bd_divider = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       out_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  // Terminal counts: START waits half a bit; DATA and STOP wait a full bit.
  localparam logic [15:0] HALF_LAST = 16'(bd_divider / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(bd_divider - 1);

  state_t      state, state_d;
  logic [15:0] clk_count, clk_count_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shift_reg, shift_d;
  logic [7:0]  data_d;
  logic        valid_d, ferr_d;
  logic        rx_m, rx_s;

  // The synchroniser resets to 1 (line idle), so reset never looks like a
  // start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so rx_m -> rx_s forms a real two-stage chain.
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      clk_count <= clk_count_d;
      bit_idx   <= bit_idx_d;
      shift_reg <= shift_d;
      data_out  <= data_d;
      out_valid <= valid_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d     = state;
    clk_count_d = clk_count + 16'd1;
    bit_idx_d   = bit_idx;
    shift_d     = shift_reg;
    data_d      = data_out;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    case (state)
      IDLE: begin
        clk_count_d = '0;
        bit_idx_d   = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        // Mid-point of the start bit. If the line is back high, the low
        // level was a glitch and is dropped.
        if (clk_count == HALF_LAST) begin
          clk_count_d = '0;
          state_d     = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (clk_count == BIT_LAST) begin
          clk_count_d      = '0;
          shift_d[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end

      STOP: begin
        // Return to IDLE at the stop-bit mid-point. This leaves half a bit
        // of margin to catch a start bit that follows immediately.
        if (clk_count == BIT_LAST) begin
          clk_count_d = '0;
          if (rx_s) begin
            data_d  = shift_reg;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end

      BRK: begin
        // Line break or stuck-low line: wait for the line to recover before
        // looking for a new start bit.
        clk_count_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        clk_count_d = '0;
        bit_idx_d   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed testbench for uart_rx with bd_divider=16. Serial frames are
//   driven on the falling clock edge, bit by bit, by a simple transmitter
//   model. Received bytes and error pulses are collected on the falling edge.
//   Each expectation is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       out_valid;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  int         ferr_cnt   = 0;
  logic       both_seen  = 1'b0;

  uart_rx #(.bd_divider(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Collect every strobe away from the active edge.
  always @(negedge clk) begin
    if (out_valid) rx_q.push_back(data_out);
    if (frame_err) ferr_cnt++;
    if (out_valid && frame_err) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Transmitter model: start bit, 8 data bits LSB first, stop bit. The line
  // is left at the stop level when the task returns.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0, BD);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BD);
    drive_bit(stop_bit, BD);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(5);

    // Single good frame 0x55
    send_frame(8'h55, 1'b1);
    idle(10);
    check("f55_count", 32'(rx_q.size()), 32'd1);
    check("f55_data", 32'(rx_q[0]), 32'h55);
    check("f55_data_out", 32'(data_out), 32'h55);
    check("f55_ferr", 32'(ferr_cnt), 32'd0);
    check("f55_busy", 32'(busy), 32'h0);

    // Glitch: low for 4 clk then high
    drive_bit(1'b0, 4);
    rx = 1'b1;
    check("glitch_busy_high", 32'(busy), 32'h1);
    idle(20);
    check("glitch_busy_low", 32'(busy), 32'h0);
    check("glitch_no_valid", 32'(rx_q.size()), 32'd1);
    check("glitch_no_ferr", 32'(ferr_cnt), 32'd0);

    // Framing error: 0xA5 with a low stop bit, line held low 40 more clk
    send_frame(8'hA5, 1'b0);
    idle(40);
    check("ferr_count", 32'(ferr_cnt), 32'd1);
    check("ferr_no_valid", 32'(rx_q.size()), 32'd1);
    check("ferr_data_held", 32'(data_out), 32'h55);
    check("ferr_busy_brk", 32'(busy), 32'h1);
    rx = 1'b1;
    idle(6);
    check("ferr_busy_released", 32'(busy), 32'h0);
    idle(10);
    send_frame(8'h12, 1'b1);
    idle(10);
    check("after_ferr_count", 32'(rx_q.size()), 32'd2);
    check("after_ferr_data", 32'(data_out), 32'h12);

    // Back-to-back frames with no idle gap
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(10);
    check("b2b_count", 32'(rx_q.size()), 32'd4);
    check("b2b_first", 32'(rx_q[2]), 32'hA5);
    check("b2b_second", 32'(rx_q[3]), 32'h3C);

    // Reset during DATA bit 3 of 0xFF
    drive_bit(1'b0, BD);
    drive_bit(1'b1, 3 * BD + 6);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    idle(8 * BD);
    check("midrst_no_valid", 32'(rx_q.size()), 32'd4);
    send_frame(8'h81, 1'b1);
    idle(10);
    check("post_rst_count", 32'(rx_q.size()), 32'd5);
    check("post_rst_data", 32'(data_out), 32'h81);

    // Loopback-style stream of three bytes from the transmitter model
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h7E, 1'b1);
    idle(10);
    check("loop_count", 32'(rx_q.size()), 32'd8);
    check("loop_b0", 32'(rx_q[5]), 32'h00);
    check("loop_b1", 32'(rx_q[6]), 32'hFF);
    check("loop_b2", 32'(rx_q[7]), 32'h7E);
    check("loop_no_ferr", 32'(ferr_cnt), 32'd1);
    check("loop_idle", 32'(busy), 32'h0);

    check("valid_ferr_exclusive", 32'(both_seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
